// File: rtl/cart_irq_ctrl_if.sv
// Register-bus bundle between the I/O register decoder and the cartridge interrupt controller.
interface cart_irq_ctrl_if;
  logic       RegWrite;
  logic [1:0] RegAddr;
  logic [7:0] RegWData;
  logic [7:0] RegRData;

  modport master (output RegWrite, RegAddr, RegWData, input RegRData);
  modport slave  (input RegWrite, RegAddr, RegWData, output RegRData);
endinterface

// File: rtl/cart_irq_ctrl.sv
// Cartridge interrupt controller: latched SPI/TF-card/MCU/timer events driving active-low nCartInt.
// Define CART_IRQ_TIMER_EN to build the periodic timer (status bit 3, TIMER_LO/TIMER_HI registers).
module cart_irq_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          PRESCALE_DIV    = 1024
) (
  input  logic           FastClk,
  input  logic           nReset,
  cart_irq_ctrl_if.slave bus,
  input  logic           SpiDone,
  input  logic           nTFDetect,
  input  logic           nMCUIrq,
  output logic           nCartInt
);

  logic        tf_s1_q, tf_s1_d, tf_s2_q, tf_s2_d;
  logic        mcu_s1_q, mcu_s1_d, mcu_s2_q, mcu_s2_d, mcu_prev_q, mcu_prev_d;
  logic        card_present_q, card_present_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [4:0]  status_q, status_d;
  logic [4:0]  enable_q, enable_d;
  logic        n_cart_int_q, n_cart_int_d;

  logic        tf_present, evt_insert, evt_remove, timer_fire;
  logic [4:0]  evt_set, w1c;
  logic [15:0] tmr_rd;
  logic [7:0]  rdata;
  logic        wr_status, wr_enable;

  assign wr_status = bus.RegWrite && (bus.RegAddr == 2'd0);
  assign wr_enable = bus.RegWrite && (bus.RegAddr == 2'd1);

`ifdef CART_IRQ_TIMER_EN
  localparam int          PW         = $clog2(PRESCALE_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);
  localparam logic [4:0]  ENABLE_MASK = 5'h1F;

  logic [7:0]    shadow_lo_q, shadow_lo_d;
  logic [15:0]   reload_q, reload_d;
  logic [15:0]   tmr_cnt_q, tmr_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          wr_tlo, wr_thi;

  assign wr_tlo = bus.RegWrite && (bus.RegAddr == 2'd2);
  assign wr_thi = bus.RegWrite && (bus.RegAddr == 2'd3);

  // A HI write restarts the period from a fresh prescaler phase, overriding any tick in that cycle.
  always_comb begin
    shadow_lo_d = shadow_lo_q;
    reload_d    = reload_q;
    tmr_cnt_d   = tmr_cnt_q;
    presc_d     = presc_q;
    timer_fire  = 1'b0;
    if (wr_tlo) shadow_lo_d = bus.RegWData;
    if (wr_thi) begin
      reload_d  = {bus.RegWData, shadow_lo_q};
      tmr_cnt_d = {bus.RegWData, shadow_lo_q};
      presc_d   = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (tmr_cnt_q == 16'd1) begin
        timer_fire = 1'b1;
        tmr_cnt_d  = reload_q;
      end else if (tmr_cnt_q != 16'd0) begin
        tmr_cnt_d = tmr_cnt_q - 16'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) begin
      shadow_lo_q <= '0;
      reload_q    <= '0;
      tmr_cnt_q   <= '0;
      presc_q     <= '0;
    end else begin
      shadow_lo_q <= shadow_lo_d;
      reload_q    <= reload_d;
      tmr_cnt_q   <= tmr_cnt_d;
      presc_q     <= presc_d;
    end
  end

  assign tmr_rd = tmr_cnt_q;
`else
  localparam logic [4:0] ENABLE_MASK = 5'h17;
  localparam int unused_prescale_div = PRESCALE_DIV;
  logic unused_wdata;

  assign timer_fire   = 1'b0;
  assign tmr_rd       = 16'h0000;
  assign unused_wdata = ^bus.RegWData[7:5];
`endif

  assign tf_present = ~tf_s2_q;

  always_comb begin
    tf_s1_d        = nTFDetect;
    tf_s2_d        = tf_s1_q;
    mcu_s1_d       = nMCUIrq;
    mcu_s2_d       = mcu_s1_q;
    mcu_prev_d     = mcu_s2_q;
    card_present_d = card_present_q;
    deb_cnt_d      = 16'd0;
    evt_insert     = 1'b0;
    evt_remove     = 1'b0;
    if (tf_present != card_present_q) begin
      if (deb_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        card_present_d = ~card_present_q;
        evt_insert     = ~card_present_q;
        evt_remove     = card_present_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 16'd1;
      end
    end
    evt_set = {mcu_prev_q & ~mcu_s2_q, timer_fire, evt_remove, evt_insert, SpiDone};
    // Setting after clearing lets a same-cycle event win over a W1C.
    w1c      = wr_status ? bus.RegWData[4:0] : 5'h00;
    status_d = (status_q & ~w1c) | evt_set;
    enable_d = wr_enable ? (bus.RegWData[4:0] & ENABLE_MASK) : enable_q;
    n_cart_int_d = ~|(status_q & enable_q);
  end

  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) begin
      tf_s1_q        <= 1'b1;
      tf_s2_q        <= 1'b1;
      mcu_s1_q       <= 1'b1;
      mcu_s2_q       <= 1'b1;
      mcu_prev_q     <= 1'b1;
      card_present_q <= 1'b0;
      deb_cnt_q      <= '0;
      status_q       <= '0;
      enable_q       <= '0;
      n_cart_int_q   <= 1'b1;
    end else begin
      tf_s1_q        <= tf_s1_d;
      tf_s2_q        <= tf_s2_d;
      mcu_s1_q       <= mcu_s1_d;
      mcu_s2_q       <= mcu_s2_d;
      mcu_prev_q     <= mcu_prev_d;
      card_present_q <= card_present_d;
      deb_cnt_q      <= deb_cnt_d;
      status_q       <= status_d;
      enable_q       <= enable_d;
      n_cart_int_q   <= n_cart_int_d;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (bus.RegAddr)
      2'd0:    rdata = {card_present_q, 2'b00, status_q};
      2'd1:    rdata = {3'b000, enable_q};
      2'd2:    rdata = tmr_rd[7:0];
      default: rdata = tmr_rd[15:8];
    endcase
  end

  assign bus.RegRData = rdata;
  assign nCartInt     = n_cart_int_q;

endmodule

// File: tb/tb_cart_irq_ctrl.sv
// Bench for cart_irq_ctrl: directed scenarios plus random traffic against an event-level reference model.
module tb_cart_irq_ctrl;
  localparam logic [15:0] DEB = 16'd8;
  localparam int          PD  = 4;
`ifdef CART_IRQ_TIMER_EN
  localparam bit HAS_TMR = 1'b1;
`else
  localparam bit HAS_TMR = 1'b0;
`endif

  logic FastClk = 1'b0;
  logic nReset = 1'b1;
  logic SpiDone = 1'b0;
  logic nTFDetect = 1'b1;
  logic nMCUIrq = 1'b1;
  logic nCartInt;

  cart_irq_ctrl_if bus();

  cart_irq_ctrl #(.DEBOUNCE_CYCLES(DEB), .PRESCALE_DIV(PD)) dut (
    .FastClk  (FastClk),
    .nReset   (nReset),
    .bus      (bus),
    .SpiDone  (SpiDone),
    .nTFDetect(nTFDetect),
    .nMCUIrq  (nMCUIrq),
    .nCartInt (nCartInt)
  );

  always #5 FastClk = ~FastClk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pin histories, debounce run length, event bits, timer in tick/phase terms.
  logic        tfq[$];
  logic        mcuq[$];
  logic        m_present;
  int          m_run;
  logic [4:0]  m_status, m_enable;
  logic        m_int;
  logic [7:0]  m_shadow;
  logic [15:0] m_reload, m_cnt;
  int          m_phase;

  int k, t1, t2;

  task automatic model_reset();
    tfq = '{1'b1, 1'b1, 1'b1};
    mcuq = '{1'b1, 1'b1, 1'b1};
    m_present = 1'b0; m_run = 0;
    m_status = '0; m_enable = '0; m_int = 1'b1;
    m_shadow = '0; m_reload = '0; m_cnt = '0; m_phase = 0;
  endtask

  task automatic model_edge();
    logic [4:0] set;
    logic [4:0] clr;
    logic       next_int;
    if (!nReset) return;
    set = '0; clr = '0;
    next_int = ~|(m_status & m_enable);
    if (SpiDone) set[0] = 1'b1;
    if (mcuq[2] && !mcuq[1]) set[4] = 1'b1;
    if ((!tfq[1]) != m_present) begin
      m_run++;
      if (m_run == int'(DEB)) begin
        m_present = ~m_present;
        if (m_present) set[1] = 1'b1; else set[2] = 1'b1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (HAS_TMR) begin
      if (bus.RegWrite && bus.RegAddr == 2'd3) begin
        m_reload = {bus.RegWData, m_shadow};
        m_cnt = m_reload;
        m_phase = 0;
      end else begin
        m_phase++;
        if (m_phase == PD) begin
          m_phase = 0;
          if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
              set[3] = 1'b1;
              m_cnt = m_reload;
            end
          end
        end
      end
      if (bus.RegWrite && bus.RegAddr == 2'd2) m_shadow = bus.RegWData;
    end
    if (bus.RegWrite && bus.RegAddr == 2'd0) clr = bus.RegWData[4:0];
    if (bus.RegWrite && bus.RegAddr == 2'd1)
      m_enable = bus.RegWData[4:0] & (HAS_TMR ? 5'h1F : 5'h17);
    m_status = (m_status & ~clr) | set;
    m_int = next_int;
    tfq.push_front(nTFDetect); void'(tfq.pop_back());
    mcuq.push_front(nMCUIrq); void'(mcuq.pop_back());
  endtask

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {m_present, 2'b00, m_status};
      2'd1:    return {3'b000, m_enable};
      2'd2:    return m_cnt[7:0];
      default: return m_cnt[15:8];
    endcase
  endfunction

  task automatic check(input string tag);
    logic [7:0] exp;
    exp = m_read(bus.RegAddr);
    n_checks++;
    assert (nCartInt === m_int) else begin
      n_fail++;
      $error("FAIL %s nCartInt observed=%b expected=%b", tag, nCartInt, m_int);
    end
    n_checks++;
    assert (bus.RegRData === exp) else begin
      n_fail++;
      $error("FAIL %s RegRData[a=%0d] observed=%h expected=%h", tag, bus.RegAddr, bus.RegRData, exp);
    end
  endtask

  task automatic expect8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge FastClk);
    model_edge();
    @(negedge FastClk);
    check(tag);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.RegWrite = 1'b1; bus.RegAddr = a; bus.RegWData = d;
    cyc("wr");
    bus.RegWrite = 1'b0;
  endtask

  task automatic do_reset(input logic tf);
    nTFDetect = tf;
    nReset = 1'b0;
    #1;
    model_reset();
    check("reset");
    repeat (2) cyc("reset_hold");
    nReset = 1'b1;
  endtask

  initial begin
    bus.RegWrite = 1'b0; bus.RegAddr = 2'd0; bus.RegWData = 8'h00;
    #2;
    do_reset(1'b1);

    // Short card-detect glitch must not change state.
    nTFDetect = 1'b0;
    repeat (5) cyc("glitch");
    nTFDetect = 1'b1;
    repeat (10) cyc("glitch");
    expect8("glitch_status", bus.RegRData, 8'h00);

    // Card present across reset: insert event after sync + debounce.
    do_reset(1'b0);
    repeat (9) cyc("insert");
    expect8("insert_early", bus.RegRData, 8'h00);
    cyc("insert");
    expect8("insert_status", bus.RegRData, 8'h82);
    expect8("insert_int", {7'd0, nCartInt}, 8'h01);
    wr(2'd0, 8'h02);

    // SPI event with enable, then W1C release.
    wr(2'd1, 8'h01);
    bus.RegAddr = 2'd0;
    SpiDone = 1'b1; cyc("spi"); SpiDone = 1'b0;
    expect8("spi_status", bus.RegRData, 8'h81);
    expect8("spi_int_n1", {7'd0, nCartInt}, 8'h01);
    cyc("spi");
    expect8("spi_int_n2", {7'd0, nCartInt}, 8'h00);
    wr(2'd0, 8'h01);
    expect8("w1c_int_s1", {7'd0, nCartInt}, 8'h00);
    cyc("w1c");
    expect8("w1c_int_s2", {7'd0, nCartInt}, 8'h01);

    // Set beats W1C in the same cycle.
    SpiDone = 1'b1; cyc("spi2"); SpiDone = 1'b0; cyc("spi2");
    SpiDone = 1'b1; wr(2'd0, 8'h01); SpiDone = 1'b0;
    bus.RegAddr = 2'd0;
    cyc("race");
    expect8("race_status", bus.RegRData, 8'h81);
    expect8("race_int", {7'd0, nCartInt}, 8'h00);
    wr(2'd0, 8'h01); wr(2'd1, 8'h00); cyc("idle");

`ifdef CART_IRQ_TIMER_EN
    // Periodic timer: reload 3, prescale 4 -> event every 12 cycles.
    wr(2'd2, 8'h03);
    wr(2'd3, 8'h00);
    wr(2'd1, 8'h08);
    bus.RegAddr = 2'd0;
    k = 1; t1 = -1; t2 = -1;
    while (k < 40 && t2 < 0) begin
      k++;
      if (t1 >= 0 && k == t1 + 1) wr(2'd0, 8'h08);
      else cyc("timer");
      if (bus.RegRData[3]) begin
        if (t1 < 0) t1 = k;
        else if (k > t1 + 1) t2 = k;
      end
    end
    expect8("timer_first", 8'(t1), 8'd12);
    expect8("timer_second", 8'(t2), 8'd24);
    wr(2'd2, 8'h00); wr(2'd3, 8'h00); wr(2'd0, 8'h08); wr(2'd1, 8'h00);
`else
    wr(2'd2, 8'h55); wr(2'd3, 8'h01); wr(2'd1, 8'h1F);
    bus.RegAddr = 2'd2; cyc("notimer");
    expect8("notimer_lo", bus.RegRData, 8'h00);
    bus.RegAddr = 2'd1; cyc("notimer");
    expect8("notimer_en", bus.RegRData, 8'h17);
    bus.RegAddr = 2'd0;
    repeat (30) cyc("notimer");
    wr(2'd1, 8'h00);
`endif

    // MCU falling edge, then held low after clearing.
    wr(2'd1, 8'h10);
    bus.RegAddr = 2'd0;
    nMCUIrq = 1'b0;
    repeat (5) cyc("mcu");
    expect8("mcu_status", bus.RegRData & 8'h1F, 8'h10);
    expect8("mcu_int", {7'd0, nCartInt}, 8'h00);
    wr(2'd0, 8'h10);
    bus.RegAddr = 2'd0;
    repeat (10) cyc("mcu_hold");
    expect8("mcu_hold_status", bus.RegRData & 8'h10, 8'h00);
    expect8("mcu_hold_int", {7'd0, nCartInt}, 8'h01);
    nMCUIrq = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.RegAddr  = 2'($urandom_range(0, 3));
      bus.RegWrite = ($urandom_range(0, 5) == 0);
      bus.RegWData = 8'($urandom);
      if (bus.RegAddr == 2'd3) bus.RegWData = 8'($urandom_range(0, 1));
      SpiDone = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) nTFDetect = ~nTFDetect;
      if ($urandom_range(0, 14) == 0) nMCUIrq = ~nMCUIrq;
      cyc("rand");
    end
    bus.RegWrite = 1'b0; SpiDone = 1'b0;

    // Asynchronous reset in the middle of a running timer with a pending interrupt.
    wr(2'd2, 8'hFF); wr(2'd3, 8'h00); wr(2'd1, 8'h1F);
    SpiDone = 1'b1; cyc("pre_rst"); SpiDone = 1'b0;
    bus.RegAddr = 2'd2;
    repeat (20) cyc("pre_rst");
    expect8("pre_rst_int", {7'd0, nCartInt}, 8'h00);
    #2;
    nReset = 1'b0;
    #1;
    model_reset();
    expect8("midrst_int", {7'd0, nCartInt}, 8'h01);
    expect8("midrst_tmr", bus.RegRData, 8'h00);
    repeat (2) cyc("midrst_hold");
    nReset = 1'b1;
    repeat (5) cyc("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
